// File: rtl/mem8x8_arbiter.sv
// Two-port round-robin arbiter for a single-ported 8x8 synchronous array.
// Every access takes a fixed four cycles: IDLE (arbitrate) -> SETUP -> ACCESS -> HOLD.
module mem8x8_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              gnt_b_q, gnt_b_d;    // operation in flight belongs to B
    logic              last_b_q, last_b_d;  // most recent grant went to B
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              pick_b;

    // Next-state logic: arbitration and command latch in IDLE, read capture leaving ACCESS.
    always_comb begin
        state_d   = state_q;
        gnt_b_d   = gnt_b_q;
        last_b_d  = last_b_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        // B wins when it is alone, or when both ask and A was served last.
        pick_b    = b_req && (!a_req || !last_b_q);
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d  = SETUP;
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    wr_d     = pick_b ? b_wr    : a_wr;
                    addr_d   = pick_b ? b_addr  : a_addr;
                    wdata_d  = pick_b ? b_wdata : a_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                state_d = HOLD;
                if (!wr_q) begin
                    if (gnt_b_q) begin
                        b_rdata_d = mem_dout;
                    end else begin
                        a_rdata_d = mem_dout;
                    end
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset leaves the pointer favouring A.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_b_q   <= gnt_b_d;
            last_b_q  <= last_b_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Enables and acks are masked by rst so an aborted operation never writes or acks.
    assign mem_we   = (state_q == ACCESS) &&  wr_q && !rst;
    assign mem_re   = (state_q == ACCESS) && !wr_q && !rst;
    assign a_ack    = (state_q == HOLD) && !gnt_b_q && !rst;
    assign b_ack    = (state_q == HOLD) &&  gnt_b_q && !rst;
    assign busy     = (state_q != IDLE);
    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_mem8x8_arbiter.sv
// Directed bench for mem8x8_arbiter with a behavioural 8x8 array model.
module tb_mem8x8_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_wr, b_req, b_wr;
    logic [2:0] a_addr, b_addr, mem_addr;
    logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_din, mem_dout;
    logic       a_ack, b_ack, mem_we, mem_re, busy;
    logic [7:0] mem [8];

    int n_cmp = 0;
    int n_err = 0;

    mem8x8_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Array model: synchronous write, read data only while mem_re is high.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
    end
    assign mem_dout = mem_re ? mem[mem_addr] : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The next edge must be the grant edge; walks SETUP/ACCESS/HOLD and ends in HOLD.
    task automatic run_op(input bit exp_b, input bit exp_wr, input logic [2:0] exp_addr,
                          input logic [7:0] exp_din, input bit drop);
        tick();
        check("setup_busy", 32'(busy), 32'd1);
        check("setup_en", 32'({mem_we, mem_re}), 32'd0);
        check("setup_addr", 32'(mem_addr), 32'(exp_addr));
        check("setup_din", 32'(mem_din), 32'(exp_din));
        check("setup_ack", 32'({a_ack, b_ack}), 32'd0);
        tick();
        check("acc_we", 32'(mem_we), 32'(exp_wr));
        check("acc_re", 32'(mem_re), 32'(!exp_wr));
        check("acc_addr", 32'(mem_addr), 32'(exp_addr));
        check("acc_ack", 32'({a_ack, b_ack}), 32'd0);
        tick();
        check("hold_en", 32'({mem_we, mem_re}), 32'd0);
        check("hold_a_ack", 32'(a_ack), 32'(!exp_b));
        check("hold_b_ack", 32'(b_ack), 32'(exp_b));
        check("hold_addr", 32'(mem_addr), 32'(exp_addr));
        check("hold_din", 32'(mem_din), 32'(exp_din));
        $display("op port=%s %s addr=%0d din=%02h a_rdata=%02h b_rdata=%02h",
                 exp_b ? "B" : "A", exp_wr ? "WR" : "RD", exp_addr, exp_din, a_rdata, b_rdata);
        if (drop) begin
            if (exp_b) b_req = 1'b0;
            else       a_req = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[1] = 8'h11;
        mem[6] = 8'h66;
        rst = 1'b1;
        a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en", 32'({mem_we, mem_re}), 32'd0);
        check("rst_ack", 32'({a_ack, b_ack}), 32'd0);
        check("rst_addr_din", 32'({mem_addr, mem_din}), 32'd0);
        check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        rst = 1'b0;

        // Write then read on port A
        a_req = 1; a_wr = 1; a_addr = 3'd5; a_wdata = 8'hA5;
        run_op(1'b0, 1'b1, 3'd5, 8'hA5, 1'b1);
        check("wr_a_rdata_kept", 32'(a_rdata), 32'd0);
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ack", 32'({a_ack, b_ack}), 32'd0);
        a_req = 1; a_wr = 0; a_addr = 3'd5;
        run_op(1'b0, 1'b0, 3'd5, 8'hA5, 1'b1);
        check("rd_a5", 32'(a_rdata), 32'hA5);
        tick();

        // Simultaneous requests after reset: A first, then B, then A again
        rst = 1'b1;
        tick();
        check("rst2_rdata", 32'(a_rdata), 32'd0);
        rst = 1'b0;
        a_req = 1; a_wr = 0; a_addr = 3'd1; a_wdata = 8'h00;
        b_req = 1; b_wr = 1; b_addr = 3'd2; b_wdata = 8'h3C;
        run_op(1'b0, 1'b0, 3'd1, 8'h00, 1'b1);
        check("rr_a_rd1", 32'(a_rdata), 32'h11);
        tick();
        check("rr_idle_busy", 32'(busy), 32'd0);
        run_op(1'b1, 1'b1, 3'd2, 8'h3C, 1'b1);
        check("rr_a_keep", 32'(a_rdata), 32'h11);
        check("rr_b_keep", 32'(b_rdata), 32'd0);
        tick();
        check("rr_mem2", 32'(mem[2]), 32'h3C);
        a_req = 1; a_wr = 0; a_addr = 3'd2;
        b_req = 1; b_wr = 0; b_addr = 3'd5;
        run_op(1'b0, 1'b0, 3'd2, 8'h00, 1'b1);
        check("rr2_a_rd2", 32'(a_rdata), 32'h3C);
        tick();
        run_op(1'b1, 1'b0, 3'd5, 8'h3C, 1'b1);
        check("rr2_b_rd5", 32'(b_rdata), 32'hA5);
        check("rr2_a_keep", 32'(a_rdata), 32'h3C);
        tick();

        // Back-to-back B requests held high
        b_req = 1; b_wr = 0; b_addr = 3'd1; b_wdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
            check("b2b_rdata", 32'(b_rdata), 32'h11);
            tick();
            check("b2b_idle", 32'(busy), 32'd0);
            check("b2b_no_a_ack", 32'(a_ack), 32'd0);
            if (i == 2) b_req = 1'b0;
        end

        // Reset during ACCESS of a write aborts it
        a_req = 1; a_wr = 1; a_addr = 3'd6; a_wdata = 8'h77;
        tick();
        tick();
        check("abort_we_pre", 32'(mem_we), 32'd1);
        rst = 1'b1;
        a_wr = 0;
        #1;
        check("abort_we_rst", 32'(mem_we), 32'd0);
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_en", 32'({mem_we, mem_re}), 32'd0);
        check("abort_ack", 32'({a_ack, b_ack}), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_mem6", 32'(mem[6]), 32'h66);
        rst = 1'b0;
        run_op(1'b0, 1'b0, 3'd6, 8'h77, 1'b1);
        check("abort_rd6", 32'(a_rdata), 32'h66);
        tick();

        // Inputs changing after the grant do not disturb the operation
        a_req = 1; a_wr = 1; a_addr = 3'd3; a_wdata = 8'h5A;
        tick();
        check("lat_setup_addr", 32'(mem_addr), 32'd3);
        a_addr = 3'd6; a_wdata = 8'hFF;
        tick();
        check("lat_acc_we", 32'(mem_we), 32'd1);
        check("lat_acc_addr", 32'(mem_addr), 32'd3);
        check("lat_acc_din", 32'(mem_din), 32'h5A);
        tick();
        check("lat_hold_ack", 32'(a_ack), 32'd1);
        check("lat_hold_addr", 32'(mem_addr), 32'd3);
        check("lat_hold_din", 32'(mem_din), 32'h5A);
        a_req = 0;
        tick();
        check("lat_mem3", 32'(mem[3]), 32'h5A);
        check("lat_mem6", 32'(mem[6]), 32'h66);

        // Random traffic: enable exclusivity and ack sanity
        for (int c = 0; c < 2000; c++) begin
            check("rnd_we_re", 32'(mem_we & mem_re), 32'd0);
            check("rnd_en_busy", 32'((mem_we | mem_re) & !busy), 32'd0);
            check("rnd_ack_excl", 32'(a_ack & b_ack), 32'd0);
            check("rnd_ack_req", 32'((a_ack & !a_req) | (b_ack & !b_req)), 32'd0);
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
            if (!a_req && $urandom_range(0, 2) == 0) begin
                a_req = 1; a_wr = 1'($urandom_range(0, 1));
                a_addr = 3'($urandom_range(0, 7)); a_wdata = 8'($urandom_range(0, 255));
            end
            if (!b_req && $urandom_range(0, 2) == 0) begin
                b_req = 1; b_wr = 1'($urandom_range(0, 1));
                b_addr = 3'($urandom_range(0, 7)); b_wdata = 8'($urandom_range(0, 255));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
